// File: rtl/instr_line_fill.sv
// Instruction line fill: on a cache miss, reads four 16-bit words of the 8-byte line and returns the assembled line.
// Latency: line_valid follows the miss_req sample by 6 cycles when mem_ready stays high, plus one cycle per stall.
// Backpressure: mem_ready low stalls the current word; MEM_TIMEOUT consecutive stalls abort the fill with an err pulse.
module instr_line_fill #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req,
  input  logic [15:0] miss_addr,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic [63:0] line_data,
  output logic [9:0]  line_tag,
  output logic [2:0]  line_index,
  output logic        line_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The stall counter is 4 bits and saturates at 15, so a larger limit is clamped to what it can reach.
  localparam int unsigned TIMEOUT_SAT = (MEM_TIMEOUT > 15) ? 15 : MEM_TIMEOUT;
  localparam logic [3:0]  TIMEOUT_LIM = TIMEOUT_SAT[3:0];

  state_t      state_q,      state_d;
  logic [12:0] base_q,       base_d;       // line address, i.e. byte address bits [15:3]
  logic [1:0]  cnt_q,        cnt_d;        // index of the word currently being fetched
  logic [3:0]  stall_q,      stall_d;      // consecutive mem_ready=0 cycles on the current word
  logic [63:0] shadow_q,     shadow_d;     // line under assembly; published only when complete
  logic        mem_rd_q,     mem_rd_d;
  logic [15:0] mem_addr_q,   mem_addr_d;
  logic [63:0] line_data_q,  line_data_d;
  logic [9:0]  line_tag_q,   line_tag_d;
  logic [2:0]  line_index_q, line_index_d;
  logic        line_valid_q, line_valid_d;
  logic        busy_q,       busy_d;
  logic        err_q,        err_d;

  // Byte offset within the line is irrelevant: a fill always covers the whole aligned line.
  logic unused_miss_lo;
  assign unused_miss_lo = ^miss_addr[2:0];

  // Next-state and registered-output computation for the fill sequencer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    stall_d      = stall_q;
    shadow_d     = shadow_q;
    line_data_d  = line_data_q;
    line_tag_d   = line_tag_q;
    line_index_d = line_index_q;
    line_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          base_d  = miss_addr[15:3];
          cnt_d   = 2'd0;
          stall_d = 4'd0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (mem_rd_q && mem_ready) begin
          // Word k goes to bits [63-16k -: 16]; ~cnt equals 3-cnt for a 2-bit count.
          shadow_d[{~cnt_q, 4'b0000} +: 16] = mem_data;
          cnt_d   = cnt_q + 2'd1;
          stall_d = 4'd0;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end
        end else begin
          stall_d = (stall_q == 4'hF) ? stall_q : stall_q + 4'd1;
          if (stall_d == TIMEOUT_LIM) begin
            // Abort: the partial line in shadow is discarded, published line untouched.
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end

      DONE: begin
        line_data_d  = shadow_q;
        line_tag_d   = base_q[12:3];
        line_index_d = base_q[2:0];
        line_valid_d = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory-side outputs follow the state being entered so they line up with it.
    mem_rd_d   = (state_d == FETCH);
    mem_addr_d = (state_d == FETCH) ? {base_d, cnt_d, 1'b0} : mem_addr_q;
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      stall_q      <= '0;
      shadow_q     <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      line_index_q <= '0;
      line_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      shadow_q     <= shadow_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      line_index_q <= line_index_d;
      line_valid_q <= line_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign line_data  = line_data_q;
  assign line_tag   = line_tag_q;
  assign line_index = line_index_q;
  assign line_valid = line_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_line_fill.sv
// Bench for instr_line_fill: directed scenarios plus randomized fills against a transaction-level model.
// The model knows only the line layout, the address sequence, the stall rule and the expected latency.
// Inputs are driven on the falling edge and outputs are sampled there too.
module tb_instr_line_fill;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_req = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic [63:0] line_data;
  logic [9:0]  line_tag;
  logic [2:0]  line_index;
  logic        line_valid;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Last line the model considers published.
  logic [63:0] exp_line = '0;
  logic [9:0]  exp_tag  = '0;
  logic [2:0]  exp_idx  = '0;

  instr_line_fill #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .line_data  (line_data),
    .line_tag   (line_tag),
    .line_index (line_index),
    .line_valid (line_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd"},     mem_rd,     0);
    chk({tag, "_mem_addr"},   mem_addr,   0);
    chk({tag, "_line_data"},  line_data,  0);
    chk({tag, "_line_tag"},   line_tag,   0);
    chk({tag, "_line_index"}, line_index, 0);
    chk({tag, "_line_valid"}, line_valid, 0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_err"},        err,        0);
  endtask

  // Caller has set miss_req/miss_addr before the rising edge that samples them.
  // After that edge miss_req/miss_addr take req_after/addr_after (to probe the busy-ignore rule).
  // Returns at the falling edge of the line_valid cycle, or of the err cycle on timeout.
  task automatic run_fill(input logic [15:0] addr, input logic [3:0][15:0] d,
                          input logic [3:0][4:0] stalls, input logic req_after,
                          input logic [15:0] addr_after);
    logic [15:0] base;
    int cyc;
    int tot;
    int st;
    bit acc;
    bit to;
    base = {addr[15:3], 3'b000};
    cyc = 0;
    tot = 0;
    to = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (!to) begin
        st = 0;
        acc = 1'b0;
        while (!acc && !to) begin
          @(negedge clk);
          cyc++;
          if (cyc == 1) begin
            miss_req  = req_after;
            miss_addr = addr_after;
            chk("pulse_end_valid", line_valid, 0);
            chk("pulse_end_err", err, 0);
          end
          chk("fetch_busy", busy, 1);
          chk("fetch_mem_rd", mem_rd, 1);
          chk("fetch_mem_addr", mem_addr, 64'(base + 16'(2 * k)));
          if (st < int'(stalls[k])) begin
            mem_ready = 1'b0;
            mem_data  = 16'($urandom);
            st++;
            tot++;
          end else begin
            mem_ready = 1'b1;
            mem_data  = d[k];
            acc = 1'b1;
          end
          @(posedge clk);
          if (!acc && st == MEM_TIMEOUT) to = 1'b1;
        end
      end
    end
    @(negedge clk);
    mem_ready = 1'($urandom);
    mem_data  = 16'($urandom);
    cyc++;
    if (to) begin
      chk("abort_err", err, 1);
      chk("abort_mem_rd", mem_rd, 0);
      chk("abort_busy", busy, 0);
      chk("abort_no_valid", line_valid, 0);
      chk("abort_line_kept", line_data, exp_line);
      chk("abort_tag_kept", line_tag, 64'(exp_tag));
    end else begin
      chk("done_busy", busy, 1);
      chk("done_mem_rd", mem_rd, 0);
      chk("done_no_valid_yet", line_valid, 0);
      chk("done_line_kept", line_data, exp_line);
      @(negedge clk);
      cyc++;
      exp_line = {d[0], d[1], d[2], d[3]};
      exp_tag  = addr[15:6];
      exp_idx  = addr[5:3];
      chk("line_valid", line_valid, 1);
      chk("line_data", line_data, exp_line);
      chk("line_tag", line_tag, 64'(exp_tag));
      chk("line_index", line_index, 64'(exp_idx));
      chk("latency", 64'(cyc), 64'(6 + tot));
      chk("idle_busy", busy, 0);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [3:0][15:0] d;
    logic [3:0][4:0]  s;
    logic [15:0]      a;
    int               r;

    // Reset state.
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Basic fill, no stalls.
    d = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    s = '0;
    miss_req = 1'b1; miss_addr = 16'h1236;
    run_fill(16'h1236, d, s, 1'b0, 16'h0000);
    chk("basic_line", line_data, 64'hA000_A001_A002_A003);
    chk("basic_tag", line_tag, 64'h048);
    chk("basic_index", line_index, 64'd6);

    // Three stall cycles before word 2.
    @(negedge clk);
    s = '0; s[2] = 5'd3;
    miss_req = 1'b1; miss_addr = 16'h1236;
    run_fill(16'h1236, d, s, 1'b0, 16'h0000);
    chk("stall_line", line_data, 64'hA000_A001_A002_A003);

    // mem_ready held low after word 1: timeout, previous line retained.
    @(negedge clk);
    s = '0; s[2] = 5'd20;
    miss_req = 1'b1; miss_addr = 16'h2000;
    run_fill(16'h2000, {16'h5555, 16'h4444, 16'h3333, 16'h2222}, s, 1'b0, 16'h0000);
    chk("timeout_line_kept", line_data, 64'hA000_A001_A002_A003);
    @(negedge clk);
    chk("timeout_err_one_cycle", err, 0);
    chk("timeout_no_late_valid", line_valid, 0);

    // New miss during a fill is ignored; still high after DONE it starts at 0xFFF8.
    s = '0;
    miss_req = 1'b1; miss_addr = 16'h1236;
    run_fill(16'h1236, d, s, 1'b1, 16'hFFF8);
    run_fill(16'hFFF8, {16'hB003, 16'hB002, 16'hB001, 16'hB000}, s, 1'b0, 16'h0000);
    chk("top_line", line_data, 64'hB000_B001_B002_B003);
    chk("top_tag", line_tag, 64'h3FF);
    chk("top_index", line_index, 64'd7);

    // Reset pulsed after word 2 is accepted.
    @(negedge clk);
    miss_req = 1'b1; miss_addr = 16'h1236;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      miss_req = 1'b0;
      mem_ready = 1'b1;
      mem_data = 16'hC000 + 16'(k);
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    exp_line = '0; exp_tag = '0; exp_idx = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_reset_no_valid", line_valid, 0);
      chk("after_reset_idle", busy, 0);
    end
    miss_req = 1'b1; miss_addr = 16'h0A5D;
    run_fill(16'h0A5D, {16'hD003, 16'hD002, 16'hD001, 16'hD000}, '0, 1'b0, 16'h0000);

    // Randomized fills.
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      a = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        d[k] = 16'($urandom);
        r = int'($urandom_range(0, 19));
        if (r < 12)      s[k] = 5'd0;
        else if (r < 18) s[k] = 5'($urandom_range(1, 5));
        else             s[k] = 5'($urandom_range(14, 16));
      end
      miss_req = 1'b1; miss_addr = a;
      run_fill(a, d, s, 1'b0, 16'h0000);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/instr_line_fill.md
INSTR_LINE_FILL -- requirements
Module: instr_line_fill

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive stall cycles allowed per word before abort.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port miss_req, input, 1: instruction cache miss request, level.
REQ-005 SHALL have port miss_addr, input, 16: instruction byte address that missed.
REQ-006 SHALL have port mem_rd, output, 1: instruction-memory read request.
REQ-007 SHALL have port mem_addr, output, 16: instruction-memory word byte address.
REQ-008 SHALL have port mem_data, input, 16: instruction-memory read data.
REQ-009 SHALL have port mem_ready, input, 1: mem_data valid for the current mem_addr.
REQ-010 SHALL have port line_data, output, 64: assembled line for cache refill.
REQ-011 SHALL have port line_tag, output, 10: tag of the filled line (miss_addr[15:6]).
REQ-012 SHALL have port line_index, output, 3: cache set of the filled line (miss_addr[5:3]).
REQ-013 SHALL have port line_valid, output, 1: one-cycle pulse; line_data, line_tag and line_index are valid.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on timeout abort.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-017 In IDLE with miss_req=1, SHALL latch base = {miss_addr[15:3],3'b000}, clear the word counter and stall counter, and enter FETCH next cycle.
REQ-018 In FETCH, SHALL drive mem_rd=1 and mem_addr = base + 2*cnt, with cnt in 0..3.
REQ-019 A word SHALL be accepted only in a cycle where mem_rd=1 and mem_ready=1; on acceptance, SHALL increment cnt and clear the stall counter.
REQ-020 Word cnt=k SHALL be stored in shadow bits [63-16k:48-16k], so word 0 lands in [63:48] and word 3 in [15:0].
REQ-021 On acceptance of word 3, SHALL enter DONE; mem_rd SHALL be 0 in DONE.
REQ-022 In DONE, SHALL copy the shadow register to line_data, drive line_tag=base[15:6] and line_index=base[5:3], pulse line_valid for exactly 1 cycle, and return to IDLE.
REQ-023 Fill latency SHALL be 6 cycles from the miss_req sample to the line_valid cycle when mem_ready is constantly 1.
REQ-024 line_data, line_tag and line_index SHALL hold their last completed values until the next DONE; partial fills SHALL NOT alter them.
REQ-025 miss_req and miss_addr SHALL be ignored while busy=1; a miss_req still high in the IDLE cycle after DONE SHALL start a new fill.
REQ-026 In FETCH, each cycle with mem_ready=0 SHALL increment a 4-bit saturating stall counter.
REQ-027 When the stall counter reaches MEM_TIMEOUT, SHALL drop mem_rd, pulse err for 1 cycle, return to IDLE, and assert no line_valid.
REQ-028 The mem_addr low bit SHALL always be 0; miss_addr[0] and miss_addr[2:1] SHALL NOT affect the fill.
REQ-029 base + 2*cnt SHALL stay within one 8-byte line; no carry out of bit 2 is possible.

Reset
REQ-030 On rst_n=0, outputs SHALL immediately be: state IDLE, mem_rd=0, mem_addr=0, line_data=0, line_tag=0, line_index=0, line_valid=0, busy=0, err=0; cnt, stall counter and shadow SHALL also clear.
REQ-031 Reset asserted mid-fill SHALL abort the fill with no line_valid pulse.
REQ-032 The first miss_req after reset SHALL start a clean fill.

Verification
REQ-033 SHALL cover: miss_addr=16'h1236, mem_ready=1, memory returns 16'hA000..16'hA003 -> mem_addr 16'h1230, 16'h1232, 16'h1234, 16'h1236; line_data=64'hA000_A001_A002_A003; line_tag=10'h048; line_index=3'd6; line_valid at cycle 6.
REQ-034 SHALL cover: same fill with mem_ready low for 3 cycles before word 2 -> mem_addr held at 16'h1234; line_valid at cycle 9; data unchanged.
REQ-035 SHALL cover: mem_ready held 0 after word 1 -> err pulse after 15 stall cycles; no line_valid; line_data keeps its previous value.
REQ-036 SHALL cover: second miss_req with miss_addr=16'hFFF8 during a fill -> ignored; after DONE with miss_req still high, a new fill starts at base 16'hFFF8 with no wrap.
REQ-037 SHALL cover: rst_n pulsed low after word 2 -> all outputs 0 asynchronously; no line_valid; the next miss completes correctly.
